// File: rtl/fir_ctrl_pkg.sv
// fir_ctrl_pkg: shared state encoding, default geometry and circular-buffer
// address helpers for the single-MAC FIR sequencer.
package fir_ctrl_pkg;

    localparam int NUM_TAPS_DEF = 11;
    localparam int ADDR_W_DEF   = 4;
    localparam int RD_LAT_DEF   = 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLEAR   = 3'd1,
        ST_WAIT_IN = 3'd2,
        ST_COMPUTE = 3'd3,
        ST_OUT     = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    // (a - b) mod n, for 0 <= a,b < n
    function automatic int mod_sub(input int a, input int b, input int n);
        int d;
        d = a - b;
        if (d < 0) d = d + n;
        return d;
    endfunction

    // (a + 1) mod n, for 0 <= a < n
    function automatic int mod_inc(input int a, input int n);
        return (a == n - 1) ? 0 : a + 1;
    endfunction

endpackage

// File: rtl/fir_ctrl_dly.sv
// fir_ctrl_dly: DEPTH-stage shift register that lines up the MAC strobes
// with the BRAM read data. DEPTH = 0 is a straight wire.
module fir_ctrl_dly import fir_ctrl_pkg::*; #(
    parameter int DEPTH = RD_LAT_DEF,
    parameter int WIDTH = 2
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    generate
        if (DEPTH == 0) begin : g_bypass
            assign dout = din;
        end else begin : g_pipe
            logic [WIDTH-1:0] stage [DEPTH];

            // shift strobes one stage per clock; cleared by reset
            always_ff @(posedge wb_clk_i) begin
                if (wb_rst_i) begin
                    for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
                end else begin
                    stage[0] <= din;
                    for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[DEPTH-1];
        end
    endgenerate

endmodule

// File: rtl/fir_ctrl.sv
// fir_ctrl: ap_start/ap_done sequencer for the single-MAC FIR engine.
// Clears the tap-delay buffer, takes one stream sample at a time, walks the
// taps through the shared BRAM+MAC datapath and presents the result.
// Optional build macro: FIR_PERF_CNT_EN (enables the perf_cycles counter;
// otherwise perf_cycles reads constant 0).
//
// state      | meaning
// -----------+-----------------------------------------------------------
// ST_IDLE    | no run active, waiting for ap_start
// ST_CLEAR   | zero the data buffer, one address per cycle
// ST_WAIT_IN | ss_tready high, waiting for the next input sample
// ST_COMPUTE | issue NUM_TAPS tap/data read addresses
// ST_OUT     | drain read latency, then hold sm_tvalid until sm_tready
// ST_DONE    | single cycle; sets sticky ap_done
module fir_ctrl import fir_ctrl_pkg::*; #(
    parameter int NUM_TAPS = NUM_TAPS_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int RD_LAT   = RD_LAT_DEF
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              ap_start,
    input  logic [31:0]       data_length,
    input  logic              done_clr,
    output logic              ap_idle,
    output logic              ap_done,
    input  logic              ss_tvalid,
    input  logic              ss_tlast,
    output logic              ss_tready,
    output logic              sm_tvalid,
    input  logic              sm_tready,
    output logic              sm_tlast,
    output logic              x_we,
    output logic              x_wzero,
    output logic [ADDR_W-1:0] x_waddr,
    output logic [ADDR_W-1:0] x_raddr,
    output logic [ADDR_W-1:0] tap_raddr,
    output logic              mac_clr,
    output logic              mac_en,
    output logic              tlast_err,
    output logic [31:0]       perf_cycles
);

    // one down-counter serves the clear sweep, the tap walk and the read drain
    localparam int TMR_MAX = (NUM_TAPS > RD_LAT) ? NUM_TAPS : RD_LAT;
    localparam int TMR_W   = $clog2(TMR_MAX + 1);

    state_t            state, state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [ADDR_W-1:0] wp;
    logic [31:0]       cnt;
    logic [31:0]       len;
    logic              done_q;
    logic              err_q;

    logic              tmr_tc;
    logic              is_last;
    logic              out_rdy;
    logic [ADDR_W-1:0] tap_k;
    logic              issue_clr;
    logic              issue_en;
    logic [1:0]        mac_dly;

    assign tmr_tc  = (tmr == '0);
    assign is_last = (cnt == len - 32'd1);
    assign out_rdy = (state == ST_OUT) && tmr_tc;
    // timer counts down, so the tap index is its distance from the load value
    assign tap_k   = ADDR_W'(TMR_W'(NUM_TAPS - 1) - tmr);

    // state register
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) state <= ST_IDLE;
        else          state <= state_nxt;
    end

    // next-state decode
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:    if (ap_start)  state_nxt = ST_CLEAR;
            ST_CLEAR:   if (tmr_tc)    state_nxt = (len == 32'd0) ? ST_DONE : ST_WAIT_IN;
            ST_WAIT_IN: if (ss_tvalid) state_nxt = ST_COMPUTE;
            ST_COMPUTE: if (tmr_tc)    state_nxt = ST_OUT;
            ST_OUT:     if (out_rdy && sm_tready) state_nxt = is_last ? ST_DONE : ST_WAIT_IN;
            ST_DONE:    state_nxt = ST_IDLE;
            default:    state_nxt = ST_IDLE;
        endcase
    end

    // output decode
    always_comb begin
        ap_idle   = (state == ST_IDLE);
        ss_tready = 1'b0;
        sm_tvalid = 1'b0;
        sm_tlast  = 1'b0;
        x_we      = 1'b0;
        x_wzero   = 1'b0;
        x_waddr   = '0;
        x_raddr   = '0;
        tap_raddr = '0;
        issue_clr = 1'b0;
        issue_en  = 1'b0;
        case (state)
            ST_CLEAR: begin
                x_we    = 1'b1;
                x_wzero = 1'b1;
                x_waddr = tap_k;
            end
            ST_WAIT_IN: begin
                ss_tready = 1'b1;
                x_we      = ss_tvalid;
                x_waddr   = wp;
            end
            ST_COMPUTE: begin
                tap_raddr = tap_k;
                x_raddr   = ADDR_W'(mod_sub(int'(wp), int'(tap_k), NUM_TAPS));
                issue_clr = (tmr == TMR_W'(NUM_TAPS - 1));
                issue_en  = (tmr != TMR_W'(NUM_TAPS - 1));
            end
            ST_OUT: begin
                sm_tvalid = tmr_tc;
                sm_tlast  = tmr_tc && is_last;
            end
            default: ;
        endcase
    end

    // run bookkeeping: timer, write pointer, sample count, sticky flags
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            tmr    <= '0;
            wp     <= '0;
            cnt    <= '0;
            len    <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (done_clr) done_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (ap_start) begin
                        len    <= data_length;
                        err_q  <= 1'b0;
                        done_q <= 1'b0;
                        cnt    <= '0;
                        wp     <= '0;
                        tmr    <= TMR_W'(NUM_TAPS - 1);
                    end
                end
                ST_CLEAR: begin
                    if (!tmr_tc) tmr <= tmr - 1'b1;
                end
                ST_WAIT_IN: begin
                    if (ss_tvalid) begin
                        tmr <= TMR_W'(NUM_TAPS - 1);
                        if (ss_tlast != is_last) err_q <= 1'b1;
                    end
                end
                ST_COMPUTE: begin
                    if (tmr_tc) tmr <= TMR_W'(RD_LAT);
                    else        tmr <= tmr - 1'b1;
                end
                ST_OUT: begin
                    if (!tmr_tc) begin
                        tmr <= tmr - 1'b1;
                    end else if (sm_tready) begin
                        wp  <= ADDR_W'(mod_inc(int'(wp), NUM_TAPS));
                        cnt <= cnt + 32'd1;
                    end
                end
                ST_DONE: begin
                    done_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign ap_done   = done_q;
    assign tlast_err = err_q;

    fir_ctrl_dly #(.DEPTH(RD_LAT), .WIDTH(2)) u_dly (
        .wb_clk_i (wb_clk_i),
        .wb_rst_i (wb_rst_i),
        .din      ({issue_clr, issue_en}),
        .dout     (mac_dly)
    );

    assign mac_clr = mac_dly[1];
    assign mac_en  = mac_dly[0];

`ifdef FIR_PERF_CNT_EN
    logic [31:0] perf_q;

    // busy-cycle counter: restarts on accept, stops once the run reaches DONE
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            perf_q <= '0;
        end else if (state == ST_IDLE && ap_start) begin
            perf_q <= '0;
        end else if (state != ST_IDLE && state != ST_DONE) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = '0;
`endif

endmodule

// File: doc/fir_ctrl.md
Name: fir_ctrl

Overview:
Sequencer for the user-project single-MAC FIR engine behind the Wishbone/AXI shim in the Caravel user area. It owns the ap_start/ap_done/ap_idle protocol, clears the tap-delay buffer, and accepts one AXI-Stream input sample at a time. For each sample it walks NUM_TAPS tap/data addresses into the shared BRAM+MAC datapath, then presents the result on the output stream. It holds no coefficient or sample data; it drives control and address lines only.

Parameters:
NUM_TAPS, 11, number of FIR taps; also the depth of the circular data buffer.
ADDR_W, 4, tap/data address width; must be >= clog2(NUM_TAPS).
RD_LAT, 1, BRAM read latency in cycles, from address issue to data at the MAC input.

Ports:
wb_clk_i  in  1  sole clock
wb_rst_i  in  1  synchronous active-high reset
ap_start  in  1  start pulse from config register; honoured only when ap_idle=1
data_length  in  32  number of samples per run, sampled at start accept
done_clr  in  1  pulse; clears sticky ap_done (config read of ap bits)
ap_idle  out  1  1 when no run is active
ap_done  out  1  sticky run-complete flag
ss_tvalid  in  1  input stream valid
ss_tlast  in  1  input stream last marker
ss_tready  out  1  input stream ready
sm_tvalid  out  1  output stream valid; data is the datapath accumulator
sm_tready  in  1  output stream ready
sm_tlast  out  1  asserted with the final output sample
x_we  out  1  data-buffer write enable
x_wzero  out  1  datapath writes 0 instead of ss_tdata
x_waddr  out  ADDR_W  data-buffer write address
x_raddr  out  ADDR_W  data-buffer read address
tap_raddr  out  ADDR_W  coefficient read address
mac_clr  out  1  load product into accumulator (first tap); aligned to MAC input
mac_en  out  1  accumulate product; aligned to MAC input
tlast_err  out  1  sticky: ss_tlast disagreed with the expected last sample
perf_cycles  out  32  run cycle count (see Optional Feature)

Behaviour:
- Reset: state IDLE. ap_idle=1. ap_done, ss_tready, sm_tvalid, sm_tlast, x_we, x_wzero, mac_clr, mac_en and tlast_err are all 0. Addresses 0, wp=0, sample count=0. Reset mid-run aborts immediately; nothing resumes.
- States:
  - IDLE: on ap_start, latch data_length, clear tlast_err, go to CLEAR. ap_idle drops the next cycle.
  - CLEAR: NUM_TAPS cycles of x_we=1, x_wzero=1, x_waddr 0..NUM_TAPS-1; wp=0. Then go to WAIT_IN, or to DONE if length=0.
  - WAIT_IN: ss_tready=1. On handshake at cycle T: x_we=1, x_waddr=wp; check ss_tlast == (count==length-1), set tlast_err on mismatch; go to COMPUTE.
  - COMPUTE: cycles T+1..T+NUM_TAPS issue k=0..NUM_TAPS-1 with tap_raddr=k and x_raddr=(wp-k) mod NUM_TAPS. mac_clr(k=0) and mac_en(k>0) are the issue strobes delayed RD_LAT cycles. Then go to OUT.
  - OUT: sm_tvalid rises at T+NUM_TAPS+RD_LAT+1 (13 cycles with the defaults) and holds until sm_tready. sm_tlast=(count==length-1). On handshake, wp=(wp+1) mod NUM_TAPS and count+1. Next state is WAIT_IN, or DONE if this was the last sample.
  - DONE: one cycle, entered the cycle after the last sm handshake. ap_done=1 and ap_idle=1 from the next cycle; return to IDLE.
- ss_tready is 0 outside WAIT_IN. There is no overlap of sample n+1 with sample n.
- ap_start while busy is ignored. ap_start and done_clr in the same cycle: both act (ap_done clears, run starts).
- ap_done stays set until done_clr or the next start accept.
- wp wraps NUM_TAPS-1 -> 0. The count is 32-bit; length is treated as unsigned.

Optional Feature:
FIR_PERF_CNT_EN:
- Defined: perf_cycles clears on start accept, increments every non-IDLE cycle, and freezes at DONE.
- Undefined: perf_cycles is constant 0; the port is still present.

Decomposition:
- Package fir_ctrl_pkg holds the state encoding (IDLE, CLEAR, WAIT_IN, COMPUTE, OUT, DONE), the NUM_TAPS/ADDR_W defaults and the mod-NUM_TAPS address helper.
- Sub-module fir_ctrl_dly: RD_LAT-deep shift register that aligns mac_clr/mac_en with BRAM read data; it resets to 0.

Test Plan:
- Reset -> ap_idle=1, ap_done=0, ss_tready=0, sm_tvalid=0; after release x_we stays 0 until ap_start.
- length=64, defaults, ss_tvalid=1, sm_tready=1 -> CLEAR writes addresses 0..10 with zero; 64 outputs; first sm_tvalid 13 cycles after the first ss handshake; sample index 2 reads x_raddr 2,1,0,10,9..3; sm_tlast only on output 64; ap_done=1 the cycle after.
- Backpressure: sm_tready=0 for 5 cycles on output 3 -> sm_tvalid and sm_tlast held, ss_tready=0, wp unchanged until handshake.
- length=0 -> CLEAR (11 cycles) then DONE; no sm_tvalid; ap_done=1, ap_idle=1.
- ap_start mid-run ignored; ss_tlast=1 on sample 10 of 64 -> tlast_err=1; done_clr -> ap_done=0.
- wb_rst_i asserted mid-COMPUTE -> IDLE, wp=0; a rerun of the length=64 case matches its timing exactly. With FIR_PERF_CNT_EN, perf_cycles equals the measured start-to-done count.
